// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/decode controller: widths, opcodes,
// controller states and the NOP encoding.
package cpu_pkg;

    localparam int PC_W    = 3;
    localparam int INSTR_W = 8;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_AND   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational field extraction from the latched instruction register.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [1:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [1:0]         mem_addr,
    output logic               alu_op,
    output logic               is_nop
);

    assign opcode   = ir[7:6];
    assign rd       = ir[5:4];
    assign rs       = ir[3:2];
    assign mem_addr = ir[1:0];
    // Only bit 6 distinguishes ADD from AND.
    assign alu_op   = ir[6];
    assign is_nop   = (ir == NOP_INSTR);

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for a tiny 8-bit ISA.
// Define FETCH_HALT_ON_WRAP_EN to enter HALT when the instruction at pc=7 retires.
module fetch_decode_ctrl
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic [PC_W-1:0]    instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic [1:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [1:0]         mem_addr,
    output logic               alu_en,
    output logic               alu_op,
    output logic               mem_re,
    output logic               mem_we,
    output logic               reg_we,
    output logic               instr_done,
    output logic               halted
);

    state_t state;
    state_t next_state;
    state_t retire_state;
    logic   is_nop;
    logic   wrap_halt;

    instr_decoder u_decoder (
        .ir       (ir),
        .opcode   (opcode),
        .rd       (rd),
        .rs       (rs),
        .mem_addr (mem_addr),
        .alu_op   (alu_op),
        .is_nop   (is_nop)
    );

    assign instr_addr = pc;

`ifdef FETCH_HALT_ON_WRAP_EN
    assign wrap_halt = (pc == '1);
    assign halted    = (state == ST_HALT);
`else
    assign wrap_halt = 1'b0;
    assign halted    = 1'b0;
`endif

    assign retire_state = wrap_halt ? ST_HALT : ST_FETCH;

    // pc advances on the same edge that instr_done is high, so it tracks retirement exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == ST_FETCH && !stall) begin
                ir <= instr_data;
            end
            if (instr_done) begin
                pc <= pc + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (!stall) begin
            case (state)
                ST_IDLE:   if (start) next_state = ST_FETCH;
                ST_FETCH:  next_state = ST_DECODE;
                ST_DECODE: begin
                    if (is_nop) begin
                        next_state = retire_state;
                    end else if (opcode == OP_ADD || opcode == OP_AND) begin
                        next_state = ST_EXEC;
                    end else begin
                        next_state = ST_MEM;
                    end
                end
                ST_EXEC:   next_state = ST_WB;
                ST_MEM:    next_state = (opcode == OP_LOAD) ? ST_WB : retire_state;
                ST_WB:     next_state = retire_state;
                ST_HALT:   next_state = ST_HALT;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Strobes are Moore outputs of the current state, all suppressed while stalled.
    always_comb begin
        alu_en     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        instr_done = 1'b0;
        if (!stall) begin
            case (state)
                ST_DECODE: instr_done = is_nop;
                ST_EXEC:   alu_en = 1'b1;
                ST_MEM: begin
                    if (opcode == OP_LOAD) begin
                        mem_re = 1'b1;
                    end else begin
                        mem_we     = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl with an 8-entry instruction ROM model.
// Expectations follow FETCH_HALT_ON_WRAP_EN when it is defined for the build.
module tb_fetch_decode_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stall;
    logic [2:0] instr_addr;
    logic [7:0] instr_data;
    logic [2:0] pc;
    logic [7:0] ir;
    logic [1:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] mem_addr;
    logic       alu_en;
    logic       alu_op;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic       instr_done;
    logic       halted;

    logic [7:0] rom [8];
    int         n_pass;
    int         n_total;

    assign instr_data = rom[instr_addr];

    fetch_decode_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .pc         (pc),
        .ir         (ir),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .mem_addr   (mem_addr),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .instr_done (instr_done),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock, landing 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_zero(input string tag);
        check({tag, "_strobes"}, {alu_en, mem_re, mem_we, reg_we, instr_done}, 5'b0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        stall   = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        rom[0] = 8'b10010001;   // LOAD  rd=01 addr=01
        rom[1] = 8'b00011000;   // ADD   rd=01 rs=10
        rom[2] = 8'b11010011;   // STORE rd=01 addr=11
        rom[3] = 8'b01100100;   // AND   rd=10 rs=01
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_pc", pc, 3'd0);
        check("rst_ir", ir, 8'h00);
        check("rst_fields", {opcode, rd, rs, mem_addr, alu_op}, 9'b0);
        check("rst_halted", halted, 1'b0);
        strobes_zero("rst");

        // LOAD: FETCH, DECODE, MEM, WB
        start = 1'b1;
        step();
        start = 1'b0;
        check("ld_fetch_addr", instr_addr, 3'd0);
        strobes_zero("ld_fetch");
        step();
        check("ld_dec_ir", ir, 8'h91);
        check("ld_dec_fields", {opcode, rd, mem_addr}, {2'b10, 2'b01, 2'b01});
        strobes_zero("ld_dec");
        step();
        check("ld_mem", {alu_en, mem_re, mem_we, reg_we, instr_done}, 5'b01000);
        step();
        check("ld_wb", {alu_en, mem_re, mem_we, reg_we, instr_done}, 5'b00011);
        step();
        check("ld_pc_after", pc, 3'd1);
        strobes_zero("ld_after");

        // ADD: FETCH, DECODE, EXEC, WB
        step();
        check("add_fields", {opcode, rd, rs}, {2'b00, 2'b01, 2'b10});
        strobes_zero("add_dec");
        step();
        check("add_exec", {alu_en, alu_op, mem_re, mem_we, reg_we, instr_done}, 6'b100000);
        step();
        check("add_wb", {alu_en, mem_re, mem_we, reg_we, instr_done}, 5'b00011);
        step();
        check("add_pc_after", pc, 3'd2);

        // STORE: FETCH, DECODE, MEM (retires)
        step();
        check("st_fields", {opcode, mem_addr}, {2'b11, 2'b11});
        step();
        check("st_mem", {alu_en, mem_re, mem_we, reg_we, instr_done}, 5'b00101);
        step();
        check("st_pc_after", pc, 3'd3);
        strobes_zero("st_after");

        // AND with a 3-cycle stall in EXEC
        step();
        check("and_fields", {opcode, rd, rs}, {2'b01, 2'b10, 2'b01});
        step();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            #1;
            check($sformatf("stall_alu_%0d", i), alu_en, 1'b0);
            check($sformatf("stall_pcir_%0d", i), {pc, ir}, {3'd3, 8'h64});
            step();
        end
        stall = 1'b0;
        #1;
        check("and_exec_release", {alu_en, alu_op, reg_we}, 3'b110);
        step();
        check("and_wb", {alu_en, reg_we, instr_done}, 3'b011);
        step();
        check("and_pc_after", {pc, ir}, {3'd4, 8'h64});

        // Eight NOPs from a clean start
        rst = 1'b1;
        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        step();
        rst   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("nop_pc_%0d", i), pc, i[2:0]);
            step();
            check($sformatf("nop_done_%0d", i), instr_done, 1'b1);
            step();
        end
`ifdef FETCH_HALT_ON_WRAP_EN
        check("wrap_halted", {halted, pc}, {1'b1, 3'd0});
        step();
        step();
        check("halt_terminal", {halted, pc, instr_done}, {1'b1, 3'd0, 1'b0});
`else
        check("wrap_pc", {halted, pc}, {1'b0, 3'd0});
        step();
        step();
        check("wrap_continue", pc, 3'd1);
`endif

        // Reset during MEM of a LOAD
        rom[0] = 8'b10010001;
        rst = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mid_mem_re", mem_re, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_state", {pc, ir, halted}, {3'd0, 8'h00, 1'b0});
        strobes_zero("mid_rst");
        step();
        step();
        check("no_restart", {pc, ir}, {3'd0, 8'h00});
        strobes_zero("no_restart");

        // Stall outranks start in IDLE
        stall = 1'b1;
        start = 1'b1;
        step();
        stall = 1'b0;
        start = 1'b0;
        step();
        step();
        check("stall_over_start", ir, 8'h00);

        // Normal restart
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("restart_ir", ir, 8'h91);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_decode_ctrl.md
FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL: start  in  1  begin execution from IDLE.
REQ-004 SHALL: stall  in  1  freeze FSM, PC and IR for the cycle.
REQ-005 SHALL: instr_addr  out  3  PC value presented to instruction memory.
REQ-006 SHALL: instr_data  in  8  instruction word from memory, combinational on instr_addr.
REQ-007 SHALL: pc  out  3  current program counter.
REQ-008 SHALL: ir  out  8  latched instruction register.
REQ-009 SHALL: opcode  out  2  ir[7:6]; 00 ADD, 01 AND, 10 LOAD, 11 STORE.
REQ-010 SHALL: rd / rs / mem_addr  out  2 each  ir[5:4] / ir[3:2] / ir[1:0].
REQ-011 SHALL: alu_en  out  1  one-cycle ALU strobe; alu_op  out  1  0=ADD, 1=AND (ir[6]).
REQ-012 SHALL: mem_re / mem_we / reg_we  out  1 each  one-cycle data-memory read, data-memory write, register-file write strobes.
REQ-013 SHALL: instr_done  out  1  one-cycle pulse on instruction retirement; halted  out  1  level, FSM in HALT.

Function
REQ-014 SHALL: FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 SHALL: IDLE -> FETCH when start=1; start outside IDLE ignored.
REQ-016 SHALL: FETCH drives instr_addr=pc, loads ir<=instr_data at edge, -> DECODE.
REQ-017 SHALL: DECODE: ir==8'h00 is NOP (retire, -> FETCH); ADD/AND -> EXEC; LOAD/STORE -> MEM.
REQ-018 SHALL: EXEC asserts alu_en for exactly one cycle, -> WB.
REQ-019 SHALL: MEM asserts mem_re (LOAD) or mem_we (STORE) one cycle; LOAD -> WB; STORE retires, -> FETCH.
REQ-020 SHALL: WB asserts reg_we one cycle, retires, -> FETCH.
REQ-021 SHALL: retirement = instr_done=1 and pc<=pc+1 (mod 8) on the same edge.
REQ-022 SHALL: latency FETCH-to-retire: NOP 2, STORE 3, ADD/AND/LOAD 4 cycles (no stall).
REQ-023 SHALL: stall=1 holds state, pc, ir; all strobes and instr_done forced 0 that cycle; stall has priority over start and transitions.
REQ-024 SHALL: opcode/rd/rs/mem_addr/alu_op decode continuously from ir; stable from DECODE until next FETCH edge.
REQ-025 SHALL: at most one of alu_en, mem_re, mem_we, reg_we asserted in any cycle.
REQ-026 SHALL: HALT is terminal; leaves only on rst; halted=1 only in HALT.

Reset
REQ-027 SHALL: rst=1 at any edge, mid-instruction included, forces IDLE, pc=0, ir=0, all strobes, instr_done and halted 0; rst overrides stall and start.
REQ-028 SHALL: outputs derived from ir read 0 after reset.

Configuration
REQ-029 SHALL: macro FETCH_HALT_ON_WRAP_EN defined: retirement at pc=3'b111 enters HALT with pc=0 instead of FETCH.
REQ-030 SHALL: macro undefined: pc wraps 7 -> 0 and execution continues; HALT unreachable, halted tied 0.

Structure
REQ-031 SHALL: shared package cpu_pkg holds opcode constants, state enum, PC width (3), instruction width (8), NOP encoding.
REQ-032 SHALL: field extraction in combinational sub-module instr_decoder (ir in; opcode, rd, rs, mem_addr, alu_op, is_nop out).

Verification
REQ-033 SHALL: rst, start pulse, memory returns 8'b10010001 at addr 0 -> FETCH,DECODE,MEM,WB; mem_re on cycle 3, reg_we on cycle 4, pc=1 after.
REQ-034 SHALL: ADD 8'b00011000 -> alu_en with alu_op=0 on EXEC, reg_we next cycle, rd=01, rs=10, 4-cycle retire.
REQ-035 SHALL: STORE 8'b11010011 -> mem_we one cycle, mem_addr=11, no reg_we, retire in 3 cycles.
REQ-036 SHALL: stall held 3 cycles during EXEC -> alu_en 0 during stall, asserted once after release, pc/ir unchanged.
REQ-037 SHALL: eight NOPs (8'h00) -> pc 0..7 then 0 (macro undefined) or halted=1 with pc=0 (macro defined).
REQ-038 SHALL: rst asserted in MEM of a LOAD -> next cycle IDLE, pc=0, ir=0, no strobes; no restart until start.
